// File: rtl/axis_out_framer.sv
// rtl/axis_out_framer.sv - frames the accelerator result stream with TLAST through a 2-entry skid buffer
// Optional statistics outputs enabled by defining AXIS_OUT_FRAMER_STAT_EN.
module axis_out_framer #(
  parameter int DW   = 64,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNTW-1:0]   len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DW-1:0]     s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DW-1:0]     m_data,
  output logic [DW/8-1:0]   m_strb,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
`ifdef AXIS_OUT_FRAMER_STAT_EN
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   frame_cnt,
  output logic              stat_ovf,
`endif
  output logic              start_err
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   len_q, len_d, in_cnt_q, in_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic              skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic [DW-1:0]     skid_data_q, skid_data_d;
  logic              done_q, done_d, start_err_q, start_err_d;
  logic              push, pop, push_last, start_ok;
`ifdef AXIS_OUT_FRAMER_STAT_EN
  logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d, frame_cnt_q, frame_cnt_d;
  logic              stat_ovf_q, stat_ovf_d;
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    in_cnt_d     = in_cnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    start_err_d  = 1'b0;
    push         = s_valid & s_ready_q;
    pop          = m_valid_q & m_ready;
    push_last    = (in_cnt_q == len_q - CNTW'(1));
    start_ok     = (state_q == IDLE) & start & (len != '0) & ~abort;
    done_d       = pop & m_last_q;

    if (push) in_cnt_d = in_cnt_q + CNTW'(1);

    // Output register is the head entry; the skid entry only fills while the head is stalled.
    if (pop) begin
      if (skid_valid_q) begin
        m_data_d     = skid_data_q;
        m_last_d     = skid_last_q;
        skid_valid_d = push;
        if (push) begin
          skid_data_d = s_data;
          skid_last_d = push_last;
        end
      end else begin
        m_valid_d = push;
        m_last_d  = push & push_last;
        if (push) m_data_d = s_data;
      end
    end else if (push) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data;
        m_last_d  = push_last;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_data;
        skid_last_d  = push_last;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && len != '0) begin
          len_d    = len;
          in_cnt_d = '0;
          state_d  = FILL;
        end else if (start) begin
          start_err_d = 1'b1;
        end
      end
      FILL:    if (push && push_last) state_d = DRAIN;
      DRAIN:   if (done_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      m_valid_d    = 1'b0;
      m_last_d     = 1'b0;
      skid_valid_d = 1'b0;
      done_d       = 1'b0;
      start_err_d  = 1'b0;
    end

    s_ready_d = (state_d == FILL) & ~(m_valid_d & skid_valid_d);

`ifdef AXIS_OUT_FRAMER_STAT_EN
    stall_cnt_d = stall_cnt_q;
    frame_cnt_d = frame_cnt_q;
    stat_ovf_d  = stat_ovf_q;
    if (start_ok) stall_cnt_d = '0;
    else if (m_valid_q && !m_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNTW'(1);
    if (stall_cnt_d == '1) stat_ovf_d = 1'b1;
    if (done_d) frame_cnt_d = frame_cnt_q + CNTW'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      in_cnt_q     <= '0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
`ifdef AXIS_OUT_FRAMER_STAT_EN
      stall_cnt_q  <= '0;
      frame_cnt_q  <= '0;
      stat_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      in_cnt_q     <= in_cnt_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
`ifdef AXIS_OUT_FRAMER_STAT_EN
      stall_cnt_q  <= stall_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      stat_ovf_q   <= stat_ovf_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign m_strb    = '1;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign start_err = start_err_q;
`ifdef AXIS_OUT_FRAMER_STAT_EN
  assign stall_cnt = stall_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign stat_ovf  = stat_ovf_q;
`endif

endmodule
